// File: rtl/vram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_port_arbiter
// Description : Shares the single-port text-VRAM BRAM between the AXI4-Lite
//               host and the video character-fetch logic. Also holds the
//               control register at word address VRAM_WORDS.
//               Every access runs IDLE -> ISSUE -> WAIT -> DONE (4 cycles).
//               Video wins arbitration by default. Host wins when it is the
//               only requester or has waited MAX_WAIT cycles.
// Ports       : axi_aclk/axi_aresetn      - clock, async active-low reset
//               host_req/we/addr/wdata/wstrb -> host_ack/host_rdata
//               vid_req/vid_addr          -> vid_ack/vid_rdata
//               bram_en/we/addr/wdata, bram_rdata - BRAM primitive port
//               ctrl_reg                  - control register contents
// Revision    : 1.0 - initial release
// ============================================================================
module vram_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int VRAM_WORDS = 600,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [DATA_W-1:0]     host_wdata,
    input  logic [DATA_W/8-1:0]   host_wstrb,
    output logic                  host_ack,
    output logic [DATA_W-1:0]     host_rdata,
    input  logic                  vid_req,
    input  logic [ADDR_W-1:0]     vid_addr,
    output logic                  vid_ack,
    output logic [DATA_W-1:0]     vid_rdata,
    output logic                  bram_en,
    output logic [DATA_W/8-1:0]   bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [DATA_W-1:0]     bram_wdata,
    input  logic [DATA_W-1:0]     bram_rdata,
    output logic [DATA_W-1:0]     ctrl_reg
);

    localparam int                STRB_W      = DATA_W / 8;
    localparam int                CNT_W       = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] C_CTRL_ADDR = ADDR_W'(VRAM_WORDS);
    localparam logic [CNT_W-1:0]  C_MAX_WAIT  = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_owner_host;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [STRB_W-1:0]  r_wstrb;
    logic [CNT_W-1:0]   r_wait_cnt;

    logic               w_host_win;
    logic               w_host_grant;
    logic               w_host_waiting;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic               w_sel_we;
    logic               w_sel_in_bram;
    logic [DATA_W-1:0]  w_rd_src;
    logic [DATA_W-1:0]  w_ctrl_next;

    // Host takes the slot when alone or once it has starved long enough.
    assign w_host_win    = host_req & (~vid_req | (r_wait_cnt >= C_MAX_WAIT));
    assign w_host_grant  = (r_state == IDLE) & w_host_win;
    // A host request held during its own in-flight access is not waiting.
    assign w_host_waiting = host_req & ~w_host_grant
                          & ~((r_state != IDLE) & r_owner_host);

    assign w_sel_addr    = w_host_win ? host_addr : vid_addr;
    assign w_sel_we      = w_host_win & host_we;
    assign w_sel_in_bram = (w_sel_addr < C_CTRL_ADDR);

    // Read source for the latched address: BRAM, control register or zero.
    assign w_rd_src = (r_addr < C_CTRL_ADDR)  ? bram_rdata :
                      (r_addr == C_CTRL_ADDR) ? ctrl_reg   : '0;

    // Byte-lane merge of the latched write into the control register.
    always_comb begin
        w_ctrl_next = ctrl_reg;
        for (int b = 0; b < STRB_W; b++) begin
            if (r_wstrb[b]) begin
                w_ctrl_next[8*b +: 8] = r_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state      <= IDLE;
            r_owner_host <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_wait_cnt   <= '0;
            ctrl_reg     <= '0;
            host_ack     <= 1'b0;
            vid_ack      <= 1'b0;
            host_rdata   <= '0;
            vid_rdata    <= '0;
            bram_en      <= 1'b0;
            bram_we      <= '0;
            bram_addr    <= '0;
            bram_wdata   <= '0;
        end else begin
            // Pulse-type outputs fall back to zero unless set below.
            host_ack   <= 1'b0;
            vid_ack    <= 1'b0;
            host_rdata <= '0;
            vid_rdata  <= '0;
            bram_en    <= 1'b0;
            bram_we    <= '0;

            if (w_host_grant) begin
                r_wait_cnt <= '0;
            end else if (w_host_waiting && (r_wait_cnt < C_MAX_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (host_req || vid_req) begin
                        r_owner_host <= w_host_win;
                        r_we         <= w_sel_we;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= host_wdata;
                        r_wstrb      <= host_wstrb;
                        // BRAM port is set up here so it is registered
                        // and valid for the whole ISSUE cycle.
                        bram_en      <= w_sel_in_bram;
                        bram_addr    <= w_sel_addr;
                        if (w_sel_we && w_sel_in_bram) begin
                            bram_we    <= host_wstrb;
                            bram_wdata <= host_wdata;
                        end
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_we && (r_addr == C_CTRL_ADDR)) begin
                        ctrl_reg <= w_ctrl_next;
                    end
                    r_state <= WAIT;
                end
                WAIT: begin
                    // bram_rdata is valid now; load the owner's result so
                    // it appears together with the ack during DONE.
                    if (r_owner_host) begin
                        host_ack   <= 1'b1;
                        host_rdata <= r_we ? '0 : w_rd_src;
                    end else begin
                        vid_ack    <= 1'b1;
                        vid_rdata  <= w_rd_src;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_port_arbiter
// Description : Self-checking bench for vram_port_arbiter. Table-driven
//               single accesses plus hand-written sequences for contention,
//               a full-memory fill/readback and reset during an access.
//               Expected acks are queued as requests are driven and
//               compared in order as the DUT acks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 40;

    logic                clk;
    logic                rst_n;
    logic                host_req, host_we;
    logic [ADDR_W-1:0]   host_addr;
    logic [DATA_W-1:0]   host_wdata;
    logic [3:0]          host_wstrb;
    logic                host_ack;
    logic [DATA_W-1:0]   host_rdata;
    logic                vid_req;
    logic [ADDR_W-1:0]   vid_addr;
    logic                vid_ack;
    logic [DATA_W-1:0]   vid_rdata;
    logic                bram_en;
    logic [3:0]          bram_we;
    logic [ADDR_W-1:0]   bram_addr;
    logic [DATA_W-1:0]   bram_wdata;
    logic [DATA_W-1:0]   bram_rdata;
    logic [DATA_W-1:0]   ctrl_reg;

    vram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .VRAM_WORDS(600), .MAX_WAIT(4)
    ) dut (
        .axi_aclk(clk),          .axi_aresetn(rst_n),
        .host_req(host_req),     .host_we(host_we),
        .host_addr(host_addr),   .host_wdata(host_wdata),
        .host_wstrb(host_wstrb), .host_ack(host_ack),
        .host_rdata(host_rdata), .vid_req(vid_req),
        .vid_addr(vid_addr),     .vid_ack(vid_ack),
        .vid_rdata(vid_rdata),   .bram_en(bram_en),
        .bram_we(bram_we),       .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .ctrl_reg(ctrl_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM: byte-enable write, one-cycle read latency.
    logic [DATA_W-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we[0]) mem[bram_addr][7:0]   <= bram_wdata[7:0];
            if (bram_we[1]) mem[bram_addr][15:8]  <= bram_wdata[15:8];
            if (bram_we[2]) mem[bram_addr][23:16] <= bram_wdata[23:16];
            if (bram_we[3]) mem[bram_addr][31:24] <= bram_wdata[31:24];
            bram_rdata <= mem[bram_addr];
        end
    end

    typedef struct {
        logic        host;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        host;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic [31:0] exp_ctrl;
    } vec_t;

    exp_t  exp_q [$];
    vec_t  vec [13];
    int    n_cmp = 0;
    int    n_err = 0;
    logic  en_seen;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endfunction

    // One cycle: advance to the falling edge, then observe the DUT.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bram_en === 1'b1) en_seen = 1'b1;
        if (host_ack === 1'b1 || vid_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'({host_ack, vid_ack}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_owner", 32'({host_ack, vid_ack}),
                    e.host ? 32'd2 : 32'd1);
                chk("ack_rdata", host_ack ? host_rdata : vid_rdata, e.rdata);
            end
        end
    endtask

    task automatic host_go(input logic we, input logic [9:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output int lat);
        tick();
        host_req = 1'b1; host_we = we; host_addr = a;
        host_wdata = d;  host_wstrb = s;
        en_seen = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (host_ack !== 1'b1 && lat < LIMIT);
        chk("host_ack_seen", 32'(host_ack), 32'd1);
        host_req = 1'b0;
    endtask

    task automatic vid_go(input logic [9:0] a, output int lat);
        tick();
        vid_req = 1'b1; vid_addr = a;
        en_seen = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (vid_ack !== 1'b1 && lat < LIMIT);
        chk("vid_ack_seen", 32'(vid_ack), 32'd1);
        vid_req = 1'b0;
    endtask

    // Both requesters re-request one cycle after every ack.
    task automatic contend(input int rounds, output int v_first,
                           output int h_first);
        int h_left, v_left, c;
        h_left = rounds; v_left = rounds;
        v_first = 0; h_first = 0; c = 0;
        tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd7;
        vid_req  = 1'b1; vid_addr = 10'd3;
        while ((h_left > 0 || v_left > 0) && c < 400) begin
            tick();
            c++;
            if (host_req && host_ack === 1'b1) begin
                host_req = 1'b0; h_left--;
                if (h_first == 0) h_first = c;
            end else if (!host_req && h_left > 0) begin
                host_req = 1'b1;
            end
            if (vid_req && vid_ack === 1'b1) begin
                vid_req = 1'b0; v_left--;
                if (v_first == 0) v_first = c;
            end else if (!vid_req && v_left > 0) begin
                vid_req = 1'b1;
            end
        end
        chk("contend_remaining", 32'(h_left + v_left), 32'd0);
        host_req = 1'b0; vid_req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_host_ack"},   32'(host_ack),   32'd0);
        chk({tag, "_vid_ack"},    32'(vid_ack),    32'd0);
        chk({tag, "_host_rdata"}, host_rdata,      32'd0);
        chk({tag, "_vid_rdata"},  vid_rdata,       32'd0);
        chk({tag, "_bram_en"},    32'(bram_en),    32'd0);
        chk({tag, "_bram_we"},    32'(bram_we),    32'd0);
        chk({tag, "_bram_addr"},  32'(bram_addr),  32'd0);
        chk({tag, "_bram_wdata"}, bram_wdata,      32'd0);
        chk({tag, "_ctrl_reg"},   ctrl_reg,        32'd0);
    endtask

    initial begin
        int lat, v_first, h_first;

        //         host  we    addr     wdata         strb   rdata         ctrl
        vec[0]  = '{1'b1, 1'b1, 10'd5,   32'h00000005, 4'hF, 32'h00000000, 32'h00000000};
        vec[1]  = '{1'b1, 1'b0, 10'd5,   32'h0,        4'h0, 32'h00000005, 32'h00000000};
        vec[2]  = '{1'b1, 1'b1, 10'd10,  32'h11223344, 4'hF, 32'h00000000, 32'h00000000};
        vec[3]  = '{1'b1, 1'b1, 10'd10,  32'hAABBCCDD, 4'h2, 32'h00000000, 32'h00000000};
        vec[4]  = '{1'b1, 1'b0, 10'd10,  32'h0,        4'h0, 32'h1122CC44, 32'h00000000};
        vec[5]  = '{1'b1, 1'b1, 10'd600, 32'h001F6000, 4'hF, 32'h00000000, 32'h001F6000};
        vec[6]  = '{1'b1, 1'b0, 10'd600, 32'h0,        4'h0, 32'h001F6000, 32'h001F6000};
        vec[7]  = '{1'b1, 1'b0, 10'd700, 32'h0,        4'h0, 32'h00000000, 32'h001F6000};
        vec[8]  = '{1'b1, 1'b1, 10'd700, 32'hDEADBEEF, 4'hF, 32'h00000000, 32'h001F6000};
        vec[9]  = '{1'b0, 1'b0, 10'd5,   32'h0,        4'h0, 32'h00000005, 32'h001F6000};
        vec[10] = '{1'b0, 1'b0, 10'd600, 32'h0,        4'h0, 32'h001F6000, 32'h001F6000};
        vec[11] = '{1'b1, 1'b1, 10'd600, 32'h12345678, 4'h5, 32'h00000000, 32'h00346078};
        vec[12] = '{1'b0, 1'b0, 10'd700, 32'h0,        4'h0, 32'h00000000, 32'h00346078};

        rst_n = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0;
        host_wdata = '0; host_wstrb = '0;
        vid_req = 1'b0;  vid_addr = '0;
        en_seen = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;

        // Table-driven single accesses.
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back('{vec[i].host, vec[i].exp_rdata});
            if (vec[i].host)
                host_go(vec[i].we, vec[i].addr, vec[i].wdata, vec[i].wstrb, lat);
            else
                vid_go(vec[i].addr, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("v%0d_bram_en", i), 32'(en_seen),
                32'(vec[i].addr < 10'd600));
            chk($sformatf("v%0d_ctrl_reg", i), ctrl_reg, vec[i].exp_ctrl);
        end

        // Contention: video first, then strict alternation.
        exp_q.push_back('{1'b1, 32'h0});
        host_go(1'b1, 10'd3, 32'h00000041, 4'hF, lat);
        exp_q.push_back('{1'b1, 32'h0});
        host_go(1'b1, 10'd7, 32'h00000042, 4'hF, lat);
        for (int r = 0; r < 4; r++) begin
            exp_q.push_back('{1'b0, 32'h00000041});
            exp_q.push_back('{1'b1, 32'h00000042});
        end
        contend(4, v_first, h_first);
        chk("contend_vid_first_latency",  32'(v_first), 32'd3);
        chk("contend_host_first_latency", 32'(h_first), 32'd7);

        // Full-memory fill and readback.
        for (int i = 0; i < 600; i++) begin
            exp_q.push_back('{1'b1, 32'h0});
            host_go(1'b1, 10'(i), 32'(i), 4'hF, lat);
            chk($sformatf("fill%0d_latency", i), 32'(lat), 32'd3);
        end
        for (int i = 0; i < 600; i++) begin
            exp_q.push_back('{1'b1, 32'(i)});
            host_go(1'b0, 10'(i), 32'h0, 4'h0, lat);
            chk($sformatf("read%0d_latency", i), 32'(lat), 32'd3);
        end

        // Reset during WAIT of a host read of the control register.
        tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd600;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1 check_zero("midrst");
        host_req = 1'b0;
        repeat (3) tick();
        chk("midrst_hold_ack", 32'({host_ack, vid_ack}), 32'd0);
        rst_n = 1'b1;
        exp_q.push_back('{1'b1, 32'h0});
        host_go(1'b0, 10'd600, 32'h0, 4'h0, lat);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_ctrl", ctrl_reg, 32'd0);
        exp_q.push_back('{1'b0, 32'd5});
        vid_go(10'd5, lat);
        chk("post_rst_vid_latency", 32'(lat), 32'd3);

        repeat (4) tick();
        chk("pending_expectations", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
